// File: rtl/uart_alu_interface_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_alu_interface_pkg
// Brief    : Shared TP2 definitions: bus width defaults, FSM state encoding
//            and ALU operation codes.
// Revision : 1.0 - initial release
// ============================================================================
package uart_alu_interface_pkg;

    localparam int NB_DATA_DEFAULT = 8;
    localparam int NB_OP_DEFAULT   = 6;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        LATCH   = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    localparam logic [NB_OP_DEFAULT-1:0] OP_ADD = 6'h20;
    localparam logic [NB_OP_DEFAULT-1:0] OP_SUB = 6'h22;
    localparam logic [NB_OP_DEFAULT-1:0] OP_AND = 6'h24;
    localparam logic [NB_OP_DEFAULT-1:0] OP_OR  = 6'h25;
    localparam logic [NB_OP_DEFAULT-1:0] OP_XOR = 6'h26;
    localparam logic [NB_OP_DEFAULT-1:0] OP_NOR = 6'h27;
    localparam logic [NB_OP_DEFAULT-1:0] OP_SRA = 6'h03;
    localparam logic [NB_OP_DEFAULT-1:0] OP_SRL = 6'h02;

    // Operand/opcode collection states, where the inter-byte timeout runs.
    function automatic logic is_frame_state(input state_t s);
        return (s == WAIT_B) || (s == WAIT_OP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_alu_interface_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_alu_interface_if
// Brief    : UART receiver/transmitter and ALU signals seen by the frame FSM.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_alu_interface_if
    import uart_alu_interface_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEFAULT,
    parameter int NB_OP   = NB_OP_DEFAULT
);
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done;
    logic               i_tx_done;
    logic [NB_DATA-1:0] i_alu_result;
    logic [NB_DATA-1:0] o_data_a;
    logic [NB_DATA-1:0] o_data_b;
    logic [NB_OP-1:0]   o_op;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_busy;
    logic               o_error;

    modport slave (
        input  i_rx_data, i_rx_done, i_tx_done, i_alu_result,
        output o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_busy, o_error
    );

    modport master (
        output i_rx_data, i_rx_done, i_tx_done, i_alu_result,
        input  o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_busy, o_error
    );
endinterface
`default_nettype wire

// File: rtl/uart_alu_interface_frame_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module   : frame_timeout_counter
// Brief    : Idle-cycle counter between frame bytes; flags the last allowed cycle.
// Revision : 1.0 - initial release
// ============================================================================
module frame_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  wire logic i_clk,
    input  wire logic i_reset,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_expired
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear wins over enable; the owner clears before the count can wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expired = (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_alu_interface.sv
`default_nettype none
// ============================================================================
// Module   : uart_alu_interface
// Brief    : Collects A, B and OP bytes from a UART, drives the ALU and sends
//            the result byte back through the UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module uart_alu_interface
    import uart_alu_interface_pkg::*;
#(
    parameter int NB_DATA        = NB_DATA_DEFAULT,
    parameter int NB_OP          = NB_OP_DEFAULT,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  wire logic            i_clk,
    input  wire logic            i_reset,
    uart_alu_interface_if.slave  bus
);
    state_t             state_q, state_d;
    logic [NB_DATA-1:0] data_a_q, data_a_d;
    logic [NB_DATA-1:0] data_b_q, data_b_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic [NB_DATA-1:0] tx_data_q, tx_data_d;

    logic w_in_frame;
    logic w_expired;
    logic w_accept;
    logic w_timeout;

    assign w_in_frame = is_frame_state(state_q);
    // A byte arriving on the expiry cycle rescues the frame.
    assign w_timeout  = w_in_frame && w_expired && !bus.i_rx_done;

    always_comb begin
        state_d   = state_q;
        data_a_d  = data_a_q;
        data_b_d  = data_b_q;
        op_d      = op_q;
        tx_data_d = tx_data_q;
        w_accept  = 1'b0;
        case (state_q)
            WAIT_A: begin
                if (bus.i_rx_done) begin
                    data_a_d = bus.i_rx_data;
                    w_accept = 1'b1;
                    state_d  = WAIT_B;
                end
            end
            WAIT_B: begin
                if (bus.i_rx_done) begin
                    data_b_d = bus.i_rx_data;
                    w_accept = 1'b1;
                    state_d  = WAIT_OP;
                end else if (w_expired) begin
                    state_d = WAIT_A;
                end
            end
            WAIT_OP: begin
                if (bus.i_rx_done) begin
                    op_d     = bus.i_rx_data[NB_OP-1:0];
                    w_accept = 1'b1;
                    state_d  = LATCH;
                end else if (w_expired) begin
                    state_d = WAIT_A;
                end
            end
            LATCH: begin
                tx_data_d = bus.i_alu_result;
                state_d   = SEND;
            end
            SEND: begin
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (bus.i_tx_done) begin
                    state_d = WAIT_A;
                end
            end
            default: begin
                state_d = WAIT_A;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= WAIT_A;
            data_a_q  <= '0;
            data_b_q  <= '0;
            op_q      <= '0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            data_a_q  <= data_a_d;
            data_b_q  <= data_b_d;
            op_q      <= op_d;
            tx_data_q <= tx_data_d;
        end
    end

    frame_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (w_accept || w_timeout),
        .i_enable  (w_in_frame),
        .o_expired (w_expired)
    );

    assign bus.o_data_a   = data_a_q;
    assign bus.o_data_b   = data_b_q;
    assign bus.o_op       = op_q;
    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_tx_start = (state_q == SEND);
    assign bus.o_busy     = (state_q != WAIT_A);
    assign bus.o_error    = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_interface.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_alu_interface
// Brief    : Randomized frame stimulus against a behavioural ALU/frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_alu_interface;
    import uart_alu_interface_pkg::*;

    localparam int TO = 16;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   n_txs;
    int   n_errs_seen;

    uart_alu_interface_if #(.NB_DATA(8), .NB_OP(6)) aif ();

    uart_alu_interface #(
        .NB_DATA        (8),
        .NB_OP          (6),
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (aif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h03:   return 8'($signed(a) >>> b);
            6'h02:   return a >> b;
            default: return 8'h00;
        endcase
    endfunction

    // Environment ALU feeding the DUT.
    assign aif.i_alu_result = alu_ref(aif.o_data_a, aif.o_data_b, aif.o_op);

    always @(negedge clk) begin
        if (aif.o_tx_start) n_txs++;
        if (aif.o_error)    n_errs_seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        aif.i_rx_data = b;
        aif.i_rx_done = 1'b1;
        idle(1);
        aif.i_rx_done = 1'b0;
        aif.i_rx_data = 8'($urandom);
    endtask

    task automatic run_frame(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op_byte, input bit inject);
        int          tx_before;
        int          err_before;
        logic [5:0]  op_exp;
        logic [7:0]  res_exp;
        tx_before  = n_txs;
        err_before = n_errs_seen;
        op_exp     = op_byte[5:0];
        res_exp    = alu_ref(a, b, op_exp);
        send_byte(a);
        idle($urandom_range(0, 3));
        send_byte(b);
        idle($urandom_range(0, 3));
        send_byte(op_byte);
        check_eq("start_early", 32'(aif.o_tx_start), 32'd0);
        check_eq("busy_latch",  32'(aif.o_busy),     32'd1);
        idle(1);
        check_eq("start_pulse", 32'(aif.o_tx_start), 32'd1);
        check_eq("tx_data",     32'(aif.o_tx_data),  32'(res_exp));
        check_eq("op",          32'(aif.o_op),       32'(op_exp));
        check_eq("data_a",      32'(aif.o_data_a),   32'(a));
        check_eq("data_b",      32'(aif.o_data_b),   32'(b));
        idle(1);
        check_eq("start_drop",  32'(aif.o_tx_start), 32'd0);
        if (inject) begin
            send_byte(8'h7F);
            check_eq("ign_data_a", 32'(aif.o_data_a), 32'(a));
            check_eq("ign_busy",   32'(aif.o_busy),   32'd1);
        end
        idle($urandom_range(0, 4));
        aif.i_tx_done = 1'b1;
        idle(1);
        aif.i_tx_done = 1'b0;
        check_eq("idle_busy",   32'(aif.o_busy),    32'd0);
        check_eq("hold_tx",     32'(aif.o_tx_data), 32'(res_exp));
        check_eq("pulse_count", 32'(n_txs - tx_before),      32'd1);
        check_eq("no_error",    32'(n_errs_seen - err_before), 32'd0);
    endtask

    initial begin
        logic [5:0] ops [8];
        n_vec = 0;
        n_err = 0;
        ops   = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL};
        rst            = 1'b1;
        aif.i_rx_data  = '0;
        aif.i_rx_done  = 1'b0;
        aif.i_tx_done  = 1'b0;
        idle(2);
        check_eq("rst_busy",  32'(aif.o_busy),     32'd0);
        check_eq("rst_start", 32'(aif.o_tx_start), 32'd0);
        check_eq("rst_error", 32'(aif.o_error),    32'd0);
        check_eq("rst_a",     32'(aif.o_data_a),   32'd0);
        check_eq("rst_tx",    32'(aif.o_tx_data),  32'd0);
        rst = 1'b0;
        idle(1);

        run_frame(8'h05, 8'h03, 8'h20, 1'b0);
        run_frame(8'h03, 8'h05, 8'h22, 1'b1);
        run_frame(8'h0F, 8'h3C, 8'hE4, 1'b0);

        // Inter-byte silence: expiry on the 16th cycle after A's strobe.
        send_byte(8'h05);
        for (int k = 1; k <= TO; k++) begin
            check_eq("timeout_err", 32'(aif.o_error), 32'(k == TO));
            if (k < TO) check_eq("timeout_busy", 32'(aif.o_busy), 32'd1);
            idle(1);
        end
        check_eq("post_to_busy", 32'(aif.o_busy),   32'd0);
        check_eq("post_to_err",  32'(aif.o_error),  32'd0);
        check_eq("post_to_a",    32'(aif.o_data_a), 32'h05);
        run_frame(8'h01, 8'h01, 8'h20, 1'b0);

        // Asynchronous reset in the middle of a frame.
        send_byte(8'h09);
        send_byte(8'h0A);
        check_eq("pre_rst_busy", 32'(aif.o_busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_busy",  32'(aif.o_busy),     32'd0);
        check_eq("arst_a",     32'(aif.o_data_a),   32'd0);
        check_eq("arst_b",     32'(aif.o_data_b),   32'd0);
        check_eq("arst_start", 32'(aif.o_tx_start), 32'd0);
        check_eq("arst_error", 32'(aif.o_error),    32'd0);
        #1 rst = 1'b0;
        idle(1);
        run_frame(8'h02, 8'h02, 8'h20, 1'b0);

        for (int i = 0; i < 24; i++) begin
            logic [7:0] opb;
            opb      = {2'($urandom), ops[$urandom_range(0, 7)]};
            run_frame(8'($urandom), 8'($urandom), opb, 1'($urandom));
        end

        check_eq("total_errors", 32'(n_errs_seen), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
